// File: rtl/rca4_serial_recover.sv
// rca4_serial_recover: bit-serial recovery of operand a from an adder result
// {cout,s} and its 2-bit addend code b, where bb = {~b[1],~b[0],b[1],b[0]}.
// One bit of a = {cout,s} - bb is resolved per clock through a registered
// borrow chain. err flags a result outside 0..2^W-1.
// Optional feature: define RCA4_SERIAL_ERRCNT_EN to add a saturating 8-bit
// err_cnt output that counts result handshakes carrying err=1.
module rca4_serial_recover #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic         cout,
  input  logic [1:0]   b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic         err
`ifdef RCA4_SERIAL_ERRCNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_live;     // low until the first clock after reset release
  logic [W:0]     r_x;        // latched {cout,s}
  logic [W-1:0]   r_bb;       // latched expanded addend
  logic           r_br;       // running borrow
  logic [IW-1:0]  r_idx;      // bit being resolved
  logic [W-1:0]   r_a;
  logic           r_err;

  logic [W-1:0]   w_bb;
  logic           w_acc;
  logic           w_last;
  logic           w_xi, w_bbi;
  logic           w_ai, w_br_nxt;
  logic           w_rel;

  // Expand the 2-bit code into the W-bit subtrahend; upper bits are zero.
  always_comb begin
    w_bb      = '0;
    w_bb[3:0] = {~b[1], ~b[0], b[1], b[0]};
  end

  assign w_acc    = in_valid & in_ready;
  assign w_rel    = (r_state == DONE) & out_ready;
  assign w_last   = (r_idx == IW'(W - 1));
  assign w_xi     = r_x[r_idx];
  assign w_bbi    = r_bb[r_idx];
  // One full-subtractor slice: difference bit and borrow out.
  assign w_ai     = w_xi ^ w_bbi ^ r_br;
  assign w_br_nxt = (~w_xi & w_bbi) | (~w_xi & r_br) | (w_bbi & r_br);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: accept, walk W bits, hold result until consumed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready stays low until the
  // first clock after reset release.
  always_comb begin
    in_ready  = (r_state == IDLE) & r_live;
    out_valid = (r_state == DONE);
  end

  // Arms in_ready one clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Serial datapath: latch on accept, resolve one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_bb  <= '0;
      r_br  <= 1'b0;
      r_idx <= '0;
      r_a   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_x   <= {cout, s};
          r_bb  <= w_bb;
          r_br  <= 1'b0;
          r_idx <= '0;
          r_a   <= '0;
        end
        RUN: begin
          r_a[r_idx] <= w_ai;
          r_br       <= w_br_nxt;
          r_idx      <= r_idx + 1'b1;
          // Bit W of the (W+1)-bit difference is set on underflow or overflow.
          if (w_last) r_err <= r_x[W] ^ w_br_nxt;
        end
        default: ;
      endcase
    end
  end

  assign a   = r_a;
  assign err = r_err;

`ifdef RCA4_SERIAL_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of consumed results that carried err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_err_cnt <= '0;
    else if (w_rel && r_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_rca4_serial_recover.sv
// Randomized self-checking bench for rca4_serial_recover against an
// arithmetic reference: a = ({cout,s} - bb) mod 2^W, err = out of range.
module tb_rca4_serial_recover;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic         cout;
  logic [1:0]   b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic         err;
`ifdef RCA4_SERIAL_ERRCNT_EN
  logic [7:0]   err_cnt;
  int           m_cnt = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rca4_serial_recover #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .cout(cout), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .err(err)
`ifdef RCA4_SERIAL_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // b codes the subtrahend 12, 9, 6, 3 for b = 0..3.
  function automatic int bb_of(input int bc);
    return 12 - 3 * bc;
  endfunction

  // One full transaction: offer x/bc, check latency, optional backpressure,
  // then consume and check the result.
  task automatic xfer(input int x, input int bc, input int stall);
    int ea, ee, lat, bb;
    bit ok;
    logic [31:0] rnd;
    logic [31:0] xv;
    logic [31:0] bv;
    bb = bb_of(bc);
    ea = (x - bb) & ((1 << W) - 1);
    ee = ((x < bb) || (x - bb > (1 << W) - 1)) ? 1 : 0;
    xv = x;
    bv = bc;
    @(negedge clk);
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin chk("in_ready_timeout", 0, 1); return; end
    in_valid = 1'b1;
    {cout, s} = xv[W:0];
    b = bv[1:0];
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
      rnd = $urandom;
      out_ready = rnd[0];   // must be ignored while running
    end
    out_ready = 1'b0;
    if (!ok) begin chk("out_valid_timeout", 0, 1); return; end
    chk("latency", lat, W);
    chk("in_ready_busy", in_ready, 0);
    for (int k = 0; k < stall; k++) begin
      chk("stall_vld", out_valid, 1);
      chk("stall_a", a, ea);
      chk("stall_err", err, ee);
      chk("stall_in_ready", in_ready, 0);
      rnd = $urandom;
      in_valid = 1'b1;        // must not be accepted while busy
      {cout, s} = rnd[W:0];
      b = rnd[9:8];
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("a", a, ea);
    chk("err", err, ee);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_clr", out_valid, 0);
    chk("a_hold", a, ea);
    chk("err_hold", err, ee);
`ifdef RCA4_SERIAL_ERRCNT_EN
    if (ee != 0 && m_cnt < 255) m_cnt++;
    chk("err_cnt", err_cnt, m_cnt);
`endif
  endtask

  initial begin
    int xr, br, sr;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s = '0; cout = 1'b0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // Directed cases.
    xfer(18, 1, 0);   // b=01 codes bb=4'b1001
    xfer(15, 0, 0);
    xfer(1, 3, 0);    // underflow
    xfer(31, 2, 0);   // overflow
    xfer(18, 1, 10);  // backpressure
    xfer(15, 0, 0);

    // Reset during the second RUN cycle, with a nonzero partial result.
    xfer(31, 2, 0);   // leaves err=1 before the reset
    @(negedge clk);
    in_valid = 1'b1; {cout, s} = 5'd18; b = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_a", a, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_in_ready", in_ready, 0);
`ifdef RCA4_SERIAL_ERRCNT_EN
    m_cnt = 0;
    chk("mid_rst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    xfer(18, 1, 0);

    // Every a with every code round-trips without error.
    for (int av = 0; av < 16; av++)
      for (int bc = 0; bc < 4; bc++)
        xfer(av + bb_of(bc), bc, 0);

    // Random words, random backpressure.
    for (int n = 0; n < 200; n++) begin
      xr = $urandom_range(0, 31);
      br = $urandom_range(0, 3);
      sr = $urandom_range(0, 3);
      xfer(xr, br, sr);
    end

    // Long run of errors drives the counter into saturation.
    for (int n = 0; n < 300; n++) xfer(31, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
